// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared 64-bit memory port between the fetch and load/store paths.
// One transaction at a time: IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
// Data normally wins arbitration. A saturating starvation counter lets a pending
// fetch override data priority once it has waited MAX_WAIT edges.
//
// state     | meaning
// ST_IDLE   | no transaction; arbitrate on any request
// ST_ACCESS | address (and write strobe) on the memory port, latency countdown
// ST_RESP   | one-cycle response pulse to the owning requester
module mem_port_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_if_q, owner_if_d;
  logic        store_q, store_d;
  logic        if_gnt_q, if_gnt_d;
  logic        dm_gnt_q, dm_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [63:0] dm_rdata_q, dm_rdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic        fetch_wins;

  // Arbitration outcome, only meaningful while IDLE
  always_comb begin
    fetch_wins = if_req && (!dm_req || (starve_cnt_q >= WAIT_LIM));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_if_d  = owner_if_q;
    store_d     = store_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_d   = ST_ACCESS;
          lat_cnt_d = LAT_INIT;
          busy_d    = 1'b1;
          if (fetch_wins) begin
            owner_if_d  = 1'b1;
            store_d     = 1'b0;
            mem_addr_d  = {32'h0, if_addr};
            mem_wdata_d = 64'h0;
            if_gnt_d    = 1'b1;
          end else begin
            owner_if_d  = 1'b0;
            store_d     = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_we ? dm_wdata : 64'h0;
            mem_wr_d    = dm_we;
            dm_gnt_d    = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          mem_addr_d  = 64'h0;
          mem_wdata_d = 64'h0;
          if (owner_if_q) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata[31:0];
          end else begin
            dm_rvalid_d = 1'b1;
            if (!store_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        mem_addr_d  = 64'h0;
        mem_wdata_d = 64'h0;
      end
    endcase
  end

  // Starvation counter: counts edges a pending fetch goes ungranted, saturating at 15
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req) begin
      starve_cnt_d = 4'd0;
    end else if ((state_q == ST_IDLE) && fetch_wins) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'd15) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State and output registers; reset drops any transaction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      owner_if_q   <= 1'b0;
      store_q      <= 1'b0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'h0;
      dm_rdata_q   <= 64'h0;
      mem_addr_q   <= 64'h0;
      mem_wdata_q  <= 64'h0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_if_q   <= owner_if_d;
      store_q      <= store_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts every output
// each cycle; directed scenarios pin the model with literal values; a second
// instance with MEM_LAT=15 covers the latency boundary.
module tb_mem_port_arbiter;

  localparam int MEM_LAT  = 3;
  localparam int MAX_WAIT = 4;

  logic        clock, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;

  logic        l_if_req, l_if_gnt, l_if_rvalid;
  logic [31:0] l_if_addr, l_if_rdata;
  logic        l_dm_req, l_dm_we, l_dm_gnt, l_dm_rvalid;
  logic [63:0] l_dm_addr, l_dm_wdata, l_dm_rdata;
  logic [63:0] l_mem_addr, l_mem_wdata, l_mem_rdata;
  logic        l_mem_wr, l_busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic        mem_mode;
  logic [63:0] mem_arr [logic [63:0]];

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(15), .MAX_WAIT(MAX_WAIT)) u_dut15 (
    .clock(clock), .reset(reset),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt), .if_rvalid(l_if_rvalid), .if_rdata(l_if_rdata),
    .dm_req(l_dm_req), .dm_we(l_dm_we), .dm_addr(l_dm_addr), .dm_wdata(l_dm_wdata),
    .dm_gnt(l_dm_gnt), .dm_rvalid(l_dm_rvalid), .dm_rdata(l_dm_rdata),
    .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_wr(l_mem_wr), .mem_rdata(l_mem_rdata), .busy(l_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a granted transaction at edge g owns cycles g..g+MEM_LAT+1
  int          edge_cnt;
  int          m_g;
  logic        m_active, m_fetch, m_we;
  logic [63:0] m_addr, m_wdata, m_dm_rdata;
  logic [31:0] m_if_rdata;
  int          m_starve;
  int          ek;
  logic        m_arb, m_fw, m_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_cnt   <= 0;
      m_g        <= 0;
      m_active   <= 1'b0;
      m_fetch    <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 64'h0;
      m_wdata    <= 64'h0;
      m_starve   <= 0;
      m_if_rdata <= 32'h0;
      m_dm_rdata <= 64'h0;
    end else begin
      ek = edge_cnt + 1;
      edge_cnt <= ek;
      if (m_active && ek == m_g + MEM_LAT) begin
        if (m_fetch) m_if_rdata <= mem_rdata[31:0];
        else if (!m_we) m_dm_rdata <= mem_rdata;
      end
      m_done = m_active && (ek == m_g + MEM_LAT + 1);
      if (m_done) m_active <= 1'b0;
      m_arb = !m_active;
      m_fw  = if_req && (!dm_req || m_starve >= MAX_WAIT);
      if (m_arb && (if_req || dm_req)) begin
        m_active <= 1'b1;
        m_g      <= ek;
        m_fetch  <= m_fw;
        m_we     <= !m_fw && dm_we;
        m_addr   <= m_fw ? {32'h0, if_addr} : dm_addr;
        m_wdata  <= (!m_fw && dm_we) ? dm_wdata : 64'h0;
      end
      if (!if_req) m_starve <= 0;
      else if (m_arb && m_fw) m_starve <= 0;
      else if (m_starve < 15) m_starve <= m_starve + 1;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clock) begin
    int   off;
    logic acc, resp, first;
    off   = edge_cnt - m_g;
    acc   = m_active && off < MEM_LAT;
    resp  = m_active && off == MEM_LAT;
    first = m_active && off == 0;
    chk("if_gnt", 64'(if_gnt), 64'(first && m_fetch));
    chk("dm_gnt", 64'(dm_gnt), 64'(first && !m_fetch));
    chk("if_rvalid", 64'(if_rvalid), 64'(resp && m_fetch));
    chk("dm_rvalid", 64'(dm_rvalid), 64'(resp && !m_fetch));
    chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("mem_addr", mem_addr, acc ? m_addr : 64'h0);
    chk("mem_wdata", mem_wdata, acc ? m_wdata : 64'h0);
    chk("mem_wr", 64'(mem_wr), 64'(first && m_we));
    chk("busy", 64'(busy), 64'(m_active));
  end

  // Memory environment: writes on the strobe, read data presented just after each edge
  initial begin
    forever begin
      @(negedge clock);
      if (mem_mode && mem_wr) mem_arr[mem_addr] = mem_wdata;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mem_mode) mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 64'h0;
      else mem_rdata = {$urandom, $urandom};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 64'(if_gnt), 64'h0);
    chk({tag, "_dm_gnt"}, 64'(dm_gnt), 64'h0);
    chk({tag, "_if_rvalid"}, 64'(if_rvalid), 64'h0);
    chk({tag, "_dm_rvalid"}, 64'(dm_rvalid), 64'h0);
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 64'h0);
    chk({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_mem_wr"}, 64'(mem_wr), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] expd);
    int rv_at;
    rv_at = -1;
    tick();
    if_req  = 1'b1;
    if_addr = a;
    tick();
    chk("fetch_gnt", 64'(if_gnt), 64'h1);
    chk("fetch_mem_addr", mem_addr, {32'h0, a});
    if_req = 1'b0;
    for (int i = 1; i <= MEM_LAT + 3; i++) begin
      tick();
      if (if_rvalid && rv_at < 0) begin
        rv_at = i;
        chk("fetch_rdata", 64'(if_rdata), 64'(expd));
      end
    end
    chk("fetch_rvalid_offset", 64'(rv_at), 64'(MEM_LAT));
    chk("fetch_busy_after", 64'(busy), 64'h0);
  endtask

  task automatic do_data(input logic we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] exp_rdata);
    int rv_at, wr_cnt;
    rv_at  = -1;
    wr_cnt = 0;
    tick();
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    tick();
    chk("data_gnt", 64'(dm_gnt), 64'h1);
    if (mem_wr) wr_cnt++;
    dm_req = 1'b0;
    for (int i = 1; i <= MEM_LAT + 3; i++) begin
      tick();
      if (mem_wr) wr_cnt++;
      if (dm_rvalid && rv_at < 0) begin
        rv_at = i;
        chk("data_rdata", dm_rdata, exp_rdata);
      end
    end
    chk("data_rvalid_offset", 64'(rv_at), 64'(MEM_LAT));
    chk("data_wr_pulses", 64'(wr_cnt), 64'(we));
  endtask

  initial begin
    int          g0, g1, n_gr, overlap, rv_cnt, dm_ev, if_seen, rv15;
    logic [63:0] got15, prev;
    logic        side;

    reset = 1'b1;
    mem_mode = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'h0; dm_wdata = 64'h0;
    mem_rdata = 64'h0;
    l_if_req = 1'b0; l_if_addr = 32'h0;
    l_dm_req = 1'b0; l_dm_we = 1'b0; l_dm_addr = 64'h0; l_dm_wdata = 64'h0;
    l_mem_rdata = 64'h0;
    mem_arr[64'h10] = 64'h00000000_00A00093;

    repeat (3) tick();
    chk_all_zero("reset");
    #2 reset = 1'b0;
    repeat (2) tick();

    do_fetch(32'h10, 32'h00A00093);

    prev = dm_rdata;
    do_data(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, prev);
    do_data(1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D);

    // Contention: both requesters held high, data re-requesting back to back
    g0 = -1; g1 = -1; n_gr = 0; overlap = 0;
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (if_gnt && dm_gnt) overlap++;
      if (dm_gnt) begin
        if (n_gr == 0) g0 = 0; else if (n_gr == 1) g1 = 0;
        n_gr++;
        dm_addr = dm_addr + 64'h8;
      end
      if (if_gnt) begin
        if (n_gr == 0) g0 = 1; else if (n_gr == 1) g1 = 1;
        n_gr++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (MEM_LAT + 3) tick();
    chk("contention_first_is_data", 64'(g0), 64'h0);
    chk("contention_second_is_fetch", 64'(g1), 64'h1);
    chk("contention_overlap", 64'(overlap), 64'h0);

    // Reset pulsed in the second ACCESS cycle of a fetch
    tick();
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    if_req = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1 chk_all_zero("midreset");
    #1 reset = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < MEM_LAT + 3; i++) begin
      tick();
      if (if_rvalid || dm_rvalid || busy) rv_cnt++;
    end
    chk("midreset_no_activity", 64'(rv_cnt), 64'h0);
    do_fetch(32'h10, 32'h00A00093);

    // Data request withdrawn while a fetch is in ACCESS
    dm_ev = 0; if_seen = 0;
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h77;
    tick();
    dm_req = 1'b0;
    for (int i = 0; i < MEM_LAT + 6; i++) begin
      tick();
      if (dm_gnt || dm_rvalid) dm_ev++;
      if (if_rvalid) if_seen++;
    end
    chk("withdraw_no_dm_activity", 64'(dm_ev), 64'h0);
    chk("withdraw_fetch_done", 64'(if_seen), 64'h1);
    chk("withdraw_fetch_rdata", 64'(if_rdata), 64'h00A00093);

    // Randomized traffic with random read data every cycle
    mem_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (if_req && if_gnt) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end else if (if_req) begin
        if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (dm_req && dm_gnt) begin
        dm_req   = ($urandom_range(0, 1) != 0);
        dm_we    = $urandom_range(0, 1) != 0;
        dm_addr  = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom};
      end else if (dm_req) begin
        if ($urandom_range(0, 15) == 0) dm_req = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        dm_req   = 1'b1;
        dm_we    = $urandom_range(0, 1) != 0;
        dm_addr  = {$urandom, $urandom};
        dm_wdata = {$urandom, $urandom};
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (MEM_LAT + 3) tick();
    chk("random_end_idle", 64'(busy), 64'h0);

    // MEM_LAT=15 instance: single load, read data tagged with the ACCESS cycle index
    rv15 = -1; got15 = 64'h0; side = 1'b0;
    tick();
    l_dm_req = 1'b1; l_dm_we = 1'b0; l_dm_addr = 64'h88;
    tick();
    chk("lat15_gnt", 64'(l_dm_gnt), 64'h1);
    chk("lat15_mem_addr", l_mem_addr, 64'h88);
    l_dm_req = 1'b0;
    l_mem_rdata = {32'hB0B0_0000, 32'd0};
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (l_dm_rvalid && rv15 < 0) begin
        rv15  = i;
        got15 = l_dm_rdata;
      end
      side = side | l_if_gnt | l_if_rvalid | l_mem_wr | (l_mem_wdata != 64'h0) | (l_if_rdata != 32'h0);
      l_mem_rdata = {32'hB0B0_0000, 32'(i)};
    end
    chk("lat15_rvalid_offset", 64'(rv15), 64'd15);
    chk("lat15_rdata", got15, 64'hB0B0_0000_0000_000E);
    chk("lat15_no_side_activity", 64'(side), 64'h0);
    chk("lat15_idle", 64'(l_busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
